// File: rtl/counter_4digit_bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : counter_4digit_bcd_pkg
// Purpose  : Shared BCD constants and nibble type for the 4-digit counter.
// Revision : 1.0 - initial release
// ============================================================================
package counter_4digit_bcd_pkg;

   typedef logic [3:0] bcd_nibble_t;

   localparam bcd_nibble_t BCD_MAX_DIGIT = 4'd9;
   localparam int          BCD_DIGITS    = 4;

endpackage
`default_nettype wire

// File: rtl/counter_4digit_bcd_if.sv
`default_nettype none
// ============================================================================
// Module   : counter_4digit_bcd_if
// Purpose  : Enable / packed-BCD count / carry bundle of the 4-digit counter.
// Revision : 1.0 - initial release
// ============================================================================
interface counter_4digit_bcd_if;
   import counter_4digit_bcd_pkg::*;

   logic        enable;
   logic [15:0] count;
   logic        cout;

   modport master (output enable, input count, input cout);
   modport slave  (input enable, output count, output cout);

endinterface
`default_nettype wire

// File: rtl/bcd_digit_counter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_counter
// Purpose  : One decimal digit with carry; out-of-range values act as 9.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit_counter
   import counter_4digit_bcd_pkg::*;
(
   input  wire logic        clk,
   input  wire logic        grst,
   input  wire logic        en_in,
   output bcd_nibble_t      digit,
   output logic             carry_out
);

   bcd_nibble_t r_digit;
   logic        w_at_max;

   // Illegal nibbles 10-15 are folded onto 9 so they wrap and carry.
   assign w_at_max = (r_digit >= BCD_MAX_DIGIT);

   always_ff @(posedge clk) begin
      if (!grst) begin
         r_digit <= '0;
      end else if (en_in) begin
         r_digit <= w_at_max ? 4'd0 : r_digit + 4'd1;
      end
   end

   assign digit     = r_digit;
   assign carry_out = en_in & w_at_max;

endmodule
`default_nettype wire

// File: rtl/counter_4digit_bcd.sv
`default_nettype none
// ============================================================================
// Module   : counter_4digit_bcd
// Purpose  : Free-running 0000-9999 packed-BCD counter with combinational cout.
// Revision : 1.0 - initial release
// ============================================================================
module counter_4digit_bcd
   import counter_4digit_bcd_pkg::*;
(
   input  wire logic             clk,
   input  wire logic             grst,
   counter_4digit_bcd_if.slave   bus
);

   logic [BCD_DIGITS:0]     w_en;
   logic [BCD_DIGITS*4-1:0] w_count;

   assign w_en[0] = bus.enable;

   // Ripple-enable chain: each digit steps only when all lower digits carry.
   generate
      for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_digit
         bcd_digit_counter u_digit (
            .clk       (clk),
            .grst      (grst),
            .en_in     (w_en[i]),
            .digit     (w_count[4*i +: 4]),
            .carry_out (w_en[i+1])
         );
      end
   endgenerate

   assign bus.count = w_count;
   assign bus.cout  = w_en[BCD_DIGITS];

endmodule
`default_nettype wire

// File: tb/tb_counter_4digit_bcd.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_counter_4digit_bcd
// Purpose  : Directed plus randomized bench against an integer mod-10000 model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_4digit_bcd;

   logic clk;
   logic grst;
   int   checks;
   int   errors;
   int   model;
   bit   known;

   counter_4digit_bcd_if bus ();

   counter_4digit_bcd dut (
      .clk  (clk),
      .grst (grst),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      r[15:12] = 4'((v / 1000) % 10);
      r[11:8]  = 4'((v / 100) % 10);
      r[7:4]   = 4'((v / 10) % 10);
      r[3:0]   = 4'(v % 10);
      return r;
   endfunction

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (model=%0d) at %0t", tag, got, exp, model, $time);
      end
   endtask

   // One clock: drive at negedge, check cout before the edge, count after it.
   task automatic cyc(input logic en, input logic rst_n);
      logic [15:0] cnt;
      @(negedge clk);
      bus.enable = en;
      grst       = rst_n;
      #1;
      if (known) check("cout", {15'd0, bus.cout}, {15'd0, (en && model == 9999)});
      @(posedge clk);
      if (!rst_n) begin
         model = 0;
         known = 1'b1;
      end else if (en) begin
         model = (model + 1) % 10000;
      end
      #1;
      if (known) begin
         cnt = bus.count;
         check("count", cnt, to_bcd(model));
         for (int d = 0; d < 4; d++) begin
            check("nibble_le9", {15'd0, (cnt[4*d +: 4] <= 4'd9)}, 16'd1);
         end
      end
   endtask

   task automatic run_to(input int target);
      int guard;
      guard = 0;
      while (model != target && guard < 10001) begin
         cyc(1'b1, 1'b1);
         guard++;
      end
      if (model != target) check("run_to_timeout", 16'(model), 16'(target));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      checks     = 0;
      errors     = 0;
      model      = 0;
      known      = 1'b0;
      grst       = 1'b1;
      bus.enable = 1'b0;

      // Reset with enable high
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      check("reset_count", bus.count, 16'h0000);
      check("reset_cout", {15'd0, bus.cout}, 16'd0);

      // Basic count with the 0009 -> 0010 step
      for (int i = 0; i < 9; i++) cyc(1'b1, 1'b1);
      check("basic_0009", bus.count, 16'h0009);
      cyc(1'b1, 1'b1);
      check("basic_0010", bus.count, 16'h0010);

      // Hold at 0123
      run_to(123);
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1);
      check("hold_count", bus.count, 16'h0123);
      check("hold_cout", {15'd0, bus.cout}, 16'd0);

      // Ripple through several digits
      run_to(999);
      cyc(1'b1, 1'b1);
      check("ripple_1000", bus.count, 16'h1000);
      run_to(1099);
      cyc(1'b1, 1'b1);
      check("ripple_1100", bus.count, 16'h1100);

      // Full 9999 edges from zero, then wrap
      cyc(1'b0, 1'b0);
      for (int i = 0; i < 9999; i++) cyc(1'b1, 1'b1);
      check("wrap_9999", bus.count, 16'h9999);
      check("wrap_cout_hi", {15'd0, bus.cout}, 16'd1);
      cyc(1'b0, 1'b1);
      check("wrap_cout_noen", {15'd0, bus.cout}, 16'd0);
      check("wrap_hold_9999", bus.count, 16'h9999);
      cyc(1'b1, 1'b1);
      check("wrap_0000", bus.count, 16'h0000);
      check("wrap_cout_lo", {15'd0, bus.cout}, 16'd0);

      // Mid-run reset
      run_to(4567);
      cyc(1'b1, 1'b0);
      check("midreset_0000", bus.count, 16'h0000);
      cyc(1'b1, 1'b1);
      check("midreset_0001", bus.count, 16'h0001);

      // Randomized enable and occasional reset
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 299) != 0));
      end

      // Random jump near the wrap to exercise cout under random enable
      run_to(9990);
      for (int i = 0; i < 40; i++) cyc($urandom_range(0, 1) == 1, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
